// File: rtl/fp8_accumulator.sv
// fp8_accumulator
//   Sums a stream of 8-bit floating-point products (sign[7], exp[6:4] bias 3,
//   mantissa[3:0] with implicit 1) into a running total using a 3-cycle
//   IDLE -> ALIGN -> NORM add, and publishes the total on a last-tagged product.
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : in_data/in_first/in_last valid
//   in_ready    : block can accept (IDLE and not in reset)
//   in_data     : product to accumulate
//   in_first    : start a new sum (add to +0 instead of the accumulator)
//   in_last     : this product closes the sum; publish the result
//   out_valid   : one-cycle pulse, out_data holds a completed sum
//   out_data    : last completed sum, held until the next publish
module fp8_accumulator #(
    parameter int GUARD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_first,
    input  logic       in_last,
    output logic       out_valid,
    output logic [7:0] out_data
);
    localparam int SW = 5 + GUARD;  // 1.mmmm plus guard bits

    typedef enum logic [1:0] {IDLE, ALIGN, NORM} state_t;
    state_t state, state_nxt;

    logic [7:0]    acc, op_a, op_b;
    logic          last_q;

    // ALIGN -> NORM pipeline registers
    logic          byp_q;
    logic [7:0]    byp_val_q;
    logic [SW-1:0] sig_x_q, sig_y_q;   // x: larger exponent, y: aligned smaller
    logic          sgn_x_q, sgn_y_q;
    logic [2:0]    exp_q;

    // ALIGN combinational
    logic          a_zero, b_zero, al_byp;
    logic [7:0]    al_byp_val;
    logic [SW-1:0] sig_a, sig_b, al_sig_x, al_sig_y;
    logic          al_sgn_x, al_sgn_y;
    logic [2:0]    al_exp, al_diff;

    // NORM combinational
    logic [SW:0]   sum;
    logic [SW-1:0] mag, nsig;
    logic          nsgn;
    int            e, lz;
    logic [7:0]    res;

    assign in_ready = (state == IDLE) & ~rst;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nxt = ALIGN;
            ALIGN:   state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_zero     = (op_a[6:0] == 7'd0);
        b_zero     = (op_b[6:0] == 7'd0);
        al_byp     = a_zero | b_zero;
        // Both-zero and any -0 collapse to 0x00; a nonzero survivor passes through.
        al_byp_val = 8'h00;
        if (a_zero && !b_zero) al_byp_val = op_b;
        else if (b_zero && !a_zero) al_byp_val = op_a;
        sig_a = {1'b1, op_a[3:0], {GUARD{1'b0}}};
        sig_b = {1'b1, op_b[3:0], {GUARD{1'b0}}};
        if (op_a[6:4] >= op_b[6:4]) begin
            al_sig_x = sig_a;  al_sgn_x = op_a[7];
            al_sig_y = sig_b;  al_sgn_y = op_b[7];
            al_exp   = op_a[6:4];
            al_diff  = op_a[6:4] - op_b[6:4];
        end else begin
            al_sig_x = sig_b;  al_sgn_x = op_b[7];
            al_sig_y = sig_a;  al_sgn_y = op_a[7];
            al_exp   = op_b[6:4];
            al_diff  = op_b[6:4] - op_a[6:4];
        end
        // A shift of SW or more naturally yields zero, so no explicit clamp.
        al_sig_y = al_sig_y >> al_diff;
    end

    always_comb begin
        sum  = {1'b0, sig_x_q} + {1'b0, sig_y_q};
        mag  = '0;
        nsig = '0;
        nsgn = sgn_x_q;
        e    = int'(exp_q);
        lz   = 0;
        res  = 8'h00;
        if (sgn_x_q == sgn_y_q) begin
            if (sum[SW]) begin
                nsig = sum[SW:1];
                e    = e + 1;
            end else begin
                nsig = sum[SW-1:0];
            end
            if (e > 7) res = {nsgn, 7'h7F};
            else       res = {nsgn, e[2:0], nsig[SW-2 -: 4]};
        end else begin
            // Aligned significands order the magnitudes directly: the
            // larger-exponent operand keeps its leading 1 in the top bit.
            if (sig_x_q >= sig_y_q) begin
                mag = sig_x_q - sig_y_q;  nsgn = sgn_x_q;
            end else begin
                mag = sig_y_q - sig_x_q;  nsgn = sgn_y_q;
            end
            for (int i = 0; i < SW; i++)
                if (mag[i]) lz = SW - 1 - i;
            nsig = mag << lz;
            e    = e - lz;
            if (mag != '0 && e >= 0) res = {nsgn, e[2:0], nsig[SW-2 -: 4]};
        end
        if (byp_q) res = byp_val_q;
        if (res[6:0] == 7'd0) res = 8'h00;  // any zero leaves as +0
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
            last_q    <= 1'b0;
            byp_q     <= 1'b0;
            byp_val_q <= 8'h00;
            sig_x_q   <= '0;
            sig_y_q   <= '0;
            sgn_x_q   <= 1'b0;
            sgn_y_q   <= 1'b0;
            exp_q     <= 3'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    op_a   <= in_first ? 8'h00 : acc;
                    op_b   <= in_data;
                    last_q <= in_last;
                end
                ALIGN: begin
                    byp_q     <= al_byp;
                    byp_val_q <= al_byp_val;
                    sig_x_q   <= al_sig_x;
                    sig_y_q   <= al_sig_y;
                    sgn_x_q   <= al_sgn_x;
                    sgn_y_q   <= al_sgn_y;
                    exp_q     <= al_exp;
                end
                NORM: begin
                    acc <= res;
                    if (last_q) begin
                        out_data  <= res;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp8_accumulator.sv
// tb_fp8_accumulator
//   Table of two-product sums plus hand sequences (single product, continuous
//   valid, zero product, reset abort). Expected sums go into a scoreboard queue
//   tagged with the cycle they must appear in; a monitor pops them on out_valid
//   and also checks in_ready goes low for the two cycles after every accept.
module tb_fp8_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_first, in_last;
    logic       in_ready, out_valid;
    logic [7:0] in_data, out_data;

    fp8_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] d; int cyc;} sb_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] y;} vec_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   accepts = 0, pulses = 0, last_acc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample mid-low-phase, away from both edges and driver updates.
    always @(negedge clk) begin
        #2;
        if (cyc == last_acc + 1 || cyc == last_acc + 2) chk("in_ready_busy", {7'd0, in_ready}, 8'd0);
        if (cyc == last_acc + 3) chk("in_ready_back", {7'd0, in_ready}, 8'd1);
        if (rst) last_acc = -100;
        if (in_valid && in_ready) begin
            accepts++;
            last_acc = cyc;
        end
        if (out_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid: got data %h, none expected (cycle %0d)", out_data, cyc);
            end else begin
                sb_t s;
                s = sb.pop_front();
                chk("out_data", out_data, s.d);
                checks++;
                if (cyc != s.cyc) begin
                    errors++;
                    $display("FAIL out_latency: got cycle %0d expected cycle %0d", cyc, s.cyc);
                end
            end
        end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
            checks++; errors++;
            $display("FAIL missing_out_valid: got none expected %h at cycle %0d", sb[0].d, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    // Entered at a negedge; holds inputs until accepted, returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] d, input logic f, input logic l,
                        input logic push, input logic [7:0] y);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        end else if (push && l) begin
            sb.push_back('{d: y, cyc: cyc + 3});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int a0, p0;
        vecs.push_back('{8'h30, 8'h40, 8'h48});  // 1 + 2 = 3
        vecs.push_back('{8'h38, 8'hB0, 8'h20});  // 1.5 - 1 = 0.5, left normalize
        vecs.push_back('{8'h38, 8'hB8, 8'h00});  // exact cancellation
        vecs.push_back('{8'h7F, 8'h7F, 8'h7F});  // positive saturation
        vecs.push_back('{8'hFF, 8'hFF, 8'hFF});  // negative saturation
        vecs.push_back('{8'h30, 8'hC0, 8'hB0});  // 1 - 2 = -1, sign of larger
        vecs.push_back('{8'h3F, 8'h01, 8'h40});  // aligned shift by 3, carry, truncation
        vecs.push_back('{8'h11, 8'h90, 8'h00});  // exponent underflow flush
        vecs.push_back('{8'h10, 8'h80, 8'h10});  // -0 operand bypass
        vecs.push_back('{8'h00, 8'h00, 8'h00});  // both zero

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_first = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_data", out_data, 8'h00);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", {7'd0, in_ready}, 8'd1);
        @(negedge clk);

        // No in_first after reset: accumulator starts from 0x00, so 2.0 + 1.0 = 3.0.
        send(8'h40, 1'b0, 1'b0, 1'b0, 8'h00);
        send(8'h30, 1'b0, 1'b1, 1'b1, 8'h48);
        drain();

        foreach (vecs[i]) begin
            send(vecs[i].a, 1'b1, 1'b0, 1'b0, 8'h00);
            send(vecs[i].b, 1'b0, 1'b1, 1'b1, vecs[i].y);
            drain();
        end

        // Single first+last products go through the zero bypass.
        send(8'h80, 1'b1, 1'b1, 1'b1, 8'h00);
        drain();
        send(8'hB5, 1'b1, 1'b1, 1'b1, 8'hB5);
        drain();

        // Continuous valid, four 1.0 products.
        a0 = accepts; p0 = pulses;
        send(8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h30, 1'b0, 1'b0, 1'b0, 8'h00);
        send(8'h30, 1'b0, 1'b0, 1'b0, 8'h00);
        send(8'h30, 1'b0, 1'b1, 1'b1, 8'h50);
        drain();
        chk("accept_count", 8'(accepts - a0), 8'd4);
        chk("pulse_count", 8'(pulses - p0), 8'd1);

        // Zero product contributes nothing.
        send(8'h30, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        send(8'h30, 1'b0, 1'b1, 1'b1, 8'h40);
        drain();

        // Reset during ALIGN aborts the pending sum.
        p0 = pulses;
        send(8'h30, 1'b1, 1'b1, 1'b0, 8'h00);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_out_data", out_data, 8'h00);
        chk("abort_no_pulse", 8'(pulses - p0), 8'd0);
        send(8'h30, 1'b1, 1'b1, 1'b1, 8'h30);
        drain();

        chk("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp8_accumulator.md
# fp8_accumulator

Downstream consumer of the 8-bit floating-point multiplier in each systolic processing element. Sums a stream of products (one dot-product column) into a running 8-bit floating-point total with a multi-cycle add, and emits the final sum on a tagged last product. Uses the multiplier's format: sign[7], exponent[6:4] (bias 3), mantissa[3:0] with implicit leading 1.

## Interface
- GUARD, 3, extra low-order significand bits kept during alignment/subtraction; discarded by truncation at write-back
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_first/in_last are valid
- in_ready  output  1  block can accept; = (state==IDLE) & ~rst
- in_data  input  8  product to accumulate
- in_first  input  1  start new sum: add in_data to +0 instead of accumulator
- in_last  input  1  this product closes the sum; publish result
- out_valid  output  1  one-cycle pulse, out_data holds a completed sum
- out_data  output  8  last completed sum; held until next publish

## Operation
- Zero encoding: exponent==0 and mantissa==0 (0x00 or 0x80) is zero; all other codes are normal values (-1)^s·1.m·2^(e-3).
- States: IDLE, ALIGN, NORM. IDLE → ALIGN on in_valid&in_ready (latch operands, first, last); ALIGN → NORM unconditionally; NORM → IDLE unconditionally.
- Operand A = in_first ? +0 : acc; operand B = in_data.
- Zero bypass (ALIGN): if one operand zero, result = other operand; both zero → 0x00; -0 always written as 0x00.
- ALIGN: significands (1.m, 5 bits) extended with GUARD zero bits; smaller-exponent operand shifted right by exponent difference (difference ≥ 5+GUARD → contributes 0); result exponent = larger exponent.
- NORM, same signs: add magnitudes; carry out → shift right 1, exponent+1; exponent > 7 → saturate to max magnitude (s_111_1111).
- NORM, different signs: larger magnitude (exponent, then significand) minus smaller; sign of larger; zero difference → 0x00; else shift left until leading 1, decrementing exponent; exponent < 0 → flush to 0x00. Result exponent 0 with mantissa 0 encodes zero (accepted loss of 2^-3).
- Mantissa = 4 bits below leading 1, truncated toward zero.
- End of NORM: acc ← result; if latched last: out_data ← result, out_valid ← 1 for one cycle.
- in_valid while in_ready low is ignored; upstream holds data.
- No in_first after reset: accumulation starts from acc reset value 0x00.

## Timing
- Accept at edge ending cycle k; ALIGN cycle k+1; NORM cycle k+2; acc/out_data/out_valid visible cycle k+3; in_ready high again cycle k+3. Max throughput one product per 3 cycles.
- out_valid registered, high exactly one cycle per last-tagged product.
- Reset values: state IDLE, acc 0x00, out_data 0x00, out_valid 0, in_ready 0 while rst high, 1 the cycle after rst deasserts.
- rst in ALIGN or NORM aborts: no acc update, no out_valid; pending operand discarded.
- in_first and in_last together: out_data = in_data (normalized via zero bypass), 3-cycle latency.

## Test plan
- Reset, then in_data=0x30 (1.0) first, 0x40 (2.0) last → out_data=0x48 (3.0), out_valid pulse in cycle k+3 after second accept, in_ready low 2 cycles after each accept.
- 0x38 (1.5) first, 0xB0 (-1.0) last → 0x20 (0.5) via left normalize.
- 0x38 first, 0xB8 last → 0x00 (exact cancellation); 0x80 first+last → 0x00.
- 0x7F first, 0x7F last → 0x7F saturated; 0xFF, 0xFF → 0xFF.
- in_valid held high continuously with 4 products (0x30 each, first on #1, last on #4) → exactly 4 accepts, out_data=0x50 (4.0), single out_valid; 0x00 product contributes nothing.
- Accept 0x30 first+last, assert rst during ALIGN → no out_valid, out_data stays 0x00; next sum 0x30 first+last → 0x30.
